// File: rtl/writeback_unit_pkg.sv
// Shared constants and types for the register-file writeback unit.
// Holds the load funct3 encodings, the FSM states and the writeback payload.
package writeback_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;

    typedef enum logic [F3_W-1:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Combinational load alignment: selects byte/halfword from a word-aligned read
// and sign- or zero-extends it; unknown funct3 behaves as LW.
module load_extend
    import writeback_unit_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        value    = rdata;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  value = {24'h000000, byte_sel};
            F3_LHU:  value = {16'h0000, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: one outstanding load plus an ALU path with a
// one-entry skid buffer; load return wins, the displaced ALU result drains next.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              ld_req_valid,
    input  logic [REG_W-1:0]  ld_req_rd,
    input  logic [F3_W-1:0]   ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    output logic              ld_req_ready,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_en,
    output logic [REG_W-1:0]  rd_index,
    output logic [XLEN-1:0]   wb_data,
    output logic              pend_valid,
    output logic [REG_W-1:0]  pend_rd
);

    wb_state_e        state_q;
    logic             pend_valid_q;
    logic [REG_W-1:0] pend_rd_q;
    logic [F3_W-1:0]  funct3_q;
    logic [1:0]       addr_lo_q;
    logic             buf_valid_q, buf_valid_d;
    wb_req_t          buf_q, buf_d;
    logic             wb_en_q;
    logic [REG_W-1:0] rd_index_q;
    logic [XLEN-1:0]  wb_data_q;

    logic             ld_ret;
    logic             alu_acc;
    logic             win;
    wb_req_t          win_req;
    logic [XLEN-1:0]  ld_value;

    load_extend u_load_extend (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (mem_rdata),
        .value   (ld_value)
    );

    assign alu_ready    = !buf_valid_q;
    assign ld_req_ready = (state_q == S_IDLE);
    assign ld_ret       = (state_q == S_LOAD_WAIT) && mem_rvalid;
    assign alu_acc      = alu_valid && !buf_valid_q;

    // Source selection: load return > buffered ALU > incoming ALU.
    always_comb begin
        win         = 1'b0;
        win_req     = '0;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (ld_ret) begin
            win     = 1'b1;
            win_req = '{rd: pend_rd_q, data: ld_value};
            if (alu_acc) begin
                buf_valid_d = 1'b1;
                buf_d       = '{rd: alu_rd, data: alu_data};
            end
        end else if (buf_valid_q) begin
            win         = 1'b1;
            win_req     = buf_q;
            buf_valid_d = 1'b0;
        end else if (alu_acc) begin
            win     = 1'b1;
            win_req = '{rd: alu_rd, data: alu_data};
        end
    end

    // Load tracking FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ld_req_valid) begin
                        state_q      <= S_LOAD_WAIT;
                        pend_valid_q <= 1'b1;
                        pend_rd_q    <= ld_req_rd;
                        funct3_q     <= ld_funct3;
                        addr_lo_q    <= ld_addr_lo;
                    end
                end
                S_LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        state_q      <= S_IDLE;
                        pend_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Skid buffer and registered writeback port; x0 writes are consumed silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            wb_en_q     <= 1'b0;
            rd_index_q  <= '0;
            wb_data_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            wb_en_q     <= win && (win_req.rd != '0);
            if (win && (win_req.rd != '0)) begin
                rd_index_q <= win_req.rd;
                wb_data_q  <= win_req.data;
            end
        end
    end

    assign wb_en      = wb_en_q;
    assign rd_index   = rd_index_q;
    assign wb_data    = wb_data_q;
    assign pend_valid = pend_valid_q;
    assign pend_rd    = pend_rd_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed cases plus randomized traffic checked
// against a transaction-level reference model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_req_valid;
    logic [4:0]  ld_req_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_req_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  rd_index;
    logic [31:0] wb_data;
    logic        pend_valid;
    logic [4:0]  pend_rd;

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_req_valid(ld_req_valid), .ld_req_rd(ld_req_rd), .ld_funct3(ld_funct3),
        .ld_addr_lo(ld_addr_lo), .ld_req_ready(ld_req_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
        .pend_valid(pend_valid), .pend_rd(pend_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding load record and a pending-ALU queue.
    bit          m_busy;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    logic [36:0] m_skid[$];
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    bit          e_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // One clock: drive at negedge, check handshakes, advance model, check writeback.
    task automatic step(input bit a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
                        input bit l_v, input logic [4:0] l_rd, input logic [2:0] l_f3,
                        input logic [1:0] l_lo, input bit m_v, input logic [31:0] m_d,
                        output bit a_acc);
        bit          ret, win, issue, exp_en;
        logic [4:0]  w_rd;
        logic [31:0] w_d;
        alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
        ld_req_valid = l_v; ld_req_rd = l_rd; ld_funct3 = l_f3; ld_addr_lo = l_lo;
        mem_rvalid = m_v; mem_rdata = m_d;
        #1;
        check_eq("alu_ready", 32'(alu_ready), 32'(m_skid.size() == 0));
        check_eq("ld_req_ready", 32'(ld_req_ready), 32'(!m_busy));
        check_eq("pend_valid", 32'(pend_valid), 32'(m_busy));
        if (m_busy) check_eq("pend_rd", 32'(pend_rd), 32'(m_rd));
        a_acc = a_v && (m_skid.size() == 0);
        ret   = m_busy && m_v;
        issue = l_v && !m_busy;
        win   = 1'b0;
        w_rd  = '0;
        w_d   = '0;
        if (ret) begin
            win = 1'b1; w_rd = m_rd; w_d = ref_load(m_f3, m_lo, m_d); m_busy = 1'b0;
            if (a_acc) m_skid.push_back({a_rd, a_d});
        end else if (m_skid.size() != 0) begin
            win = 1'b1; {w_rd, w_d} = m_skid.pop_front();
        end else if (a_acc) begin
            win = 1'b1; w_rd = a_rd; w_d = a_d;
        end
        if (issue) begin
            m_busy = 1'b1; m_rd = l_rd; m_f3 = l_f3; m_lo = l_lo;
        end
        exp_en = win && (w_rd != 0);
        if (exp_en) begin
            e_rd = w_rd; e_data = w_d; e_known = 1'b1;
        end else if (win) begin
            e_known = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("wb_en", 32'(wb_en), 32'(exp_en));
        if (e_known) begin
            check_eq("rd_index", 32'(rd_index), 32'(e_rd));
            check_eq("wb_data", wb_data, e_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_req_valid = 0; ld_req_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Asynchronous reset pulse in the middle of the low clock phase.
    task automatic do_reset();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_wb_en", 32'(wb_en), 32'd0);
        check_eq("rst_rd_index", 32'(rd_index), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_pend_valid", 32'(pend_valid), 32'd0);
        check_eq("rst_pend_rd", 32'(pend_rd), 32'd0);
        check_eq("rst_ld_req_ready", 32'(ld_req_ready), 32'd1);
        check_eq("rst_alu_ready", 32'(alu_ready), 32'd1);
        m_busy = 0; m_skid.delete(); e_rd = 0; e_data = 0; e_known = 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    bit          acc;
    bit          hold_v;
    logic [4:0]  hold_rd;
    logic [31:0] hold_d;

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_busy = 0; e_rd = 0; e_data = 0; e_known = 1;
        repeat (2) @(negedge clk);
        do_reset();

        // LB at offset 3
        step(0, 0, 0, 1, 5'd9, 3'b000, 2'd3, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_1234, acc);
        check_eq("lb_ofs3", wb_data, 32'hFFFF_FF80);
        // LHU / LH at offset 2
        step(0, 0, 0, 1, 5'd10, 3'b101, 2'd2, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_0000, acc);
        check_eq("lhu_ofs2", wb_data, 32'h0000_8001);
        step(0, 0, 0, 1, 5'd11, 3'b001, 2'd2, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_0000, acc);
        check_eq("lh_ofs2", wb_data, 32'hFFFF_8001);
        // Load return collides with an ALU result
        step(0, 0, 0, 1, 5'd3, 3'b010, 2'd1, 0, 0, acc);
        step(1, 5'd5, 32'h1234, 0, 0, 0, 0, 1, 32'hCAFE_F00D, acc);
        check_eq("collide_ld_rd", 32'(rd_index), 32'd3);
        check_eq("collide_alu_ready", 32'(alu_ready), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        check_eq("collide_x5", wb_data, 32'h1234);
        check_eq("collide_ready_back", 32'(alu_ready), 32'd1);
        // ALU write to x0
        step(1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, acc);
        check_eq("x0_suppressed", 32'(wb_en), 32'd0);
        // Reset while a load is outstanding
        step(0, 0, 0, 1, 5'd7, 3'b010, 2'd0, 0, 0, acc);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222, acc);
        check_eq("stale_rvalid_wb_en", 32'(wb_en), 32'd0);
        check_eq("stale_ld_req_ready", 32'(ld_req_ready), 32'd1);
        // Back-to-back ALU results
        for (int i = 1; i <= 4; i++) begin
            step(1, 5'(i), 32'(i * 32'h0101_0101), 0, 0, 0, 0, 0, 0, acc);
            check_eq("b2b_rd", 32'(rd_index), 32'(i));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Randomized traffic; refused ALU results are held by the source
        hold_v = 0; hold_rd = 0; hold_d = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold_v && ($urandom_range(0, 99) < 60)) begin
                hold_v = 1; hold_rd = 5'($urandom); hold_d = $urandom;
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                hold_v = 0;
            end else begin
                step(hold_v, hold_rd, hold_d,
                     ($urandom_range(0, 99) < 40), 5'($urandom), 3'($urandom), 2'($urandom),
                     ($urandom_range(0, 99) < 35), $urandom, acc);
                if (acc) hold_v = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
